subtract_and_restore: RTL and testbench

SUBTRACT_AND_RESTORE -- requirements
Module: subtract_and_restore

---
 rtl/reorder_pkg.sv | 25 ++
 rtl/prefix_diff.sv | 37 +++
 rtl/subtract_and_restore.sv | 164 ++++++++++++++++
 tb/tb_subtract_and_restore.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_pkg.sv
// ============================================================================
// Module      : reorder_pkg
// Description : Shared definitions for the reorder/add (forward) block and
//               the subtract_and_restore (inverse) block. Holds the frame
//               geometry defaults and the two-state FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reorder_pkg;

  // Default frame geometry: elements per frame, data width, index width
  localparam int unsigned C_N  = 9;
  localparam int unsigned C_DW = 8;
  localparam int unsigned C_IW = 4;

  // Frame FSM: gather beats, then present the restored frame
  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_e;

endpackage : reorder_pkg

`default_nettype wire

// File: rtl/prefix_diff.sv
// ============================================================================
// Module      : prefix_diff
// Description : Recovers one element from a running (prefix) sum.
//               A zero sum after the first beat marks a restart of the
//               running sum, so the element is taken as 0 rather than
//               as a wrapped difference.
// Ports       : cur   - running sum at the current position
//               prev  - running sum at the previous position
//               first - current beat is the first of the frame
//               x     - recovered element
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefix_diff #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] cur,
  input  logic [DW-1:0] prev,
  input  logic          first,
  output logic [DW-1:0] x
);

  always_comb begin
    if (first) begin
      x = cur;
    end else if (cur == '0) begin
      x = '0;
    end else begin
      // Modulo-2^DW difference; the borrow is intentionally dropped
      x = cur - prev;
    end
  end

endmodule : prefix_diff

`default_nettype wire

// File: rtl/subtract_and_restore.sv
// ============================================================================
// Module      : subtract_and_restore
// Description : Collects N sum/index beats, recovers each element from the
//               running sum and scatters it into its destination slot, then
//               presents the restored frame until downstream accepts it.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               in_valid/in_ready   - beat handshake
//               in_sum, in_index    - running sum and destination slot
//               out_valid/out_ready - frame handshake
//               data_out0..8        - restored elements in original order
//               err                 - some beat of this frame had index >= N
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtract_and_restore
  import reorder_pkg::*;
#(
  parameter int unsigned N  = C_N,
  parameter int unsigned DW = C_DW,
  parameter int unsigned IW = C_IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sum,
  input  logic [IW-1:0] in_index,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_out0,
  output logic [DW-1:0] data_out1,
  output logic [DW-1:0] data_out2,
  output logic [DW-1:0] data_out3,
  output logic [DW-1:0] data_out4,
  output logic [DW-1:0] data_out5,
  output logic [DW-1:0] data_out6,
  output logic [DW-1:0] data_out7,
  output logic [DW-1:0] data_out8,
  output logic          err
);

  localparam int unsigned C_CW   = $clog2(N + 1);
  localparam int unsigned C_NOUT = 9;  // number of data_out ports

  state_e          r_state;
  state_e          w_state_nxt;
  logic [C_CW-1:0] r_count;
  logic [DW-1:0]   r_prev;
  logic [DW-1:0]   r_slot [N];
  logic            r_err;

  logic            w_accept;
  logic            w_handoff;
  logic            w_last;
  logic            w_first;
  logic            w_idx_ok;
  logic [DW-1:0]   w_x;
  logic [DW-1:0]   w_out [C_NOUT];

  assign w_accept  = in_valid & in_ready;
  assign w_handoff = out_valid & out_ready;
  assign w_first   = (r_count == '0);
  assign w_last    = w_accept && (r_count == C_CW'(N - 1));
  assign w_idx_ok  = (32'(in_index) < N);

  prefix_diff #(
    .DW (DW)
  ) u_prefix_diff (
    .cur   (in_sum),
    .prev  (r_prev),
    .first (w_first),
    .x     (w_x)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (w_last)    w_state_nxt = ST_EMIT;
      ST_EMIT:    if (w_handoff) w_state_nxt = ST_COLLECT;
      default:                   w_state_nxt = ST_COLLECT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. in_ready is low throughout EMIT, so no beat can be taken
  // in the handoff cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_COLLECT: in_ready  = 1'b1;
      ST_EMIT:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Beat counter, previous sum, error flag and slot array. Handoff wipes the
  // frame so unwritten slots of the next frame read zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_prev  <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < int'(N); i++) r_slot[i] <= '0;
    end else if (w_handoff) begin
      r_count <= '0;
      r_prev  <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < int'(N); i++) r_slot[i] <= '0;
    end else if (w_accept) begin
      r_count <= r_count + C_CW'(1);
      r_prev  <= in_sum;
      if (!w_idx_ok) r_err <= 1'b1;
      // Later beats overwrite earlier ones with the same index
      for (int i = 0; i < int'(N); i++) begin
        if (w_idx_ok && (in_index == IW'(i))) r_slot[i] <= w_x;
      end
    end
  end

  // Map slots onto the fixed set of output ports; ports beyond N read zero
  for (genvar gi = 0; gi < C_NOUT; gi++) begin : g_out
    if (gi < N) begin : g_used
      assign w_out[gi] = r_slot[gi];
    end else begin : g_unused
      assign w_out[gi] = '0;
    end
  end

  assign data_out0 = w_out[0];
  assign data_out1 = w_out[1];
  assign data_out2 = w_out[2];
  assign data_out3 = w_out[3];
  assign data_out4 = w_out[4];
  assign data_out5 = w_out[5];
  assign data_out6 = w_out[6];
  assign data_out7 = w_out[7];
  assign data_out8 = w_out[8];
  assign err       = r_err;

endmodule : subtract_and_restore

`default_nettype wire

// File: tb/tb_subtract_and_restore.sv
// ============================================================================
// Module      : tb_subtract_and_restore
// Description : Self-checking bench for subtract_and_restore. Frames come
//               from a table of {sums, indices, expected elements, err};
//               expected frames are queued when driven and popped when the
//               DUT presents a frame. Hand-written sequences cover
//               backpressure and reset in the middle of a frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subtract_and_restore;

  localparam int unsigned C_N  = 9;
  localparam int unsigned C_DW = 8;
  localparam int unsigned C_IW = 4;

  typedef struct packed {
    logic [8:0][7:0] sums;
    logic [8:0][3:0] idx;
    logic [8:0][7:0] exp;
    logic            err;
  } vec_t;

  typedef struct packed {
    logic [8:0][7:0] d;
    logic            e;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [C_DW-1:0] in_sum;
  logic [C_IW-1:0] in_index;
  logic            out_valid;
  logic            out_ready;
  logic [C_DW-1:0] data_out0, data_out1, data_out2, data_out3, data_out4;
  logic [C_DW-1:0] data_out5, data_out6, data_out7, data_out8;
  logic            err;
  logic [7:0]      w_dout [9];

  int   n_vec = 0;
  int   n_mis = 0;
  exp_t sb [$];
  vec_t vecs [6];
  vec_t rv;

  always #5 clk = ~clk;

  subtract_and_restore #(
    .N  (C_N),
    .DW (C_DW),
    .IW (C_IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_index  (in_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3),
    .data_out4 (data_out4),
    .data_out5 (data_out5),
    .data_out6 (data_out6),
    .data_out7 (data_out7),
    .data_out8 (data_out8),
    .err       (err)
  );

  assign w_dout[0] = data_out0;
  assign w_dout[1] = data_out1;
  assign w_dout[2] = data_out2;
  assign w_dout[3] = data_out3;
  assign w_dout[4] = data_out4;
  assign w_dout[5] = data_out5;
  assign w_dout[6] = data_out6;
  assign w_dout[7] = data_out7;
  assign w_dout[8] = data_out8;

  // Build a 9-element array from a concatenation written element 0 first
  function automatic logic [8:0][7:0] pk8(input logic [71:0] x);
    logic [8:0][7:0] r;
    for (int k = 0; k < 9; k++) r[k] = x[71-8*k -: 8];
    return r;
  endfunction

  function automatic logic [8:0][3:0] pk4(input logic [35:0] x);
    logic [8:0][3:0] r;
    for (int k = 0; k < 9; k++) r[k] = x[35-4*k -: 4];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one beat (with an occasional idle cycle first) and wait for it
  task automatic drive_beat(input logic [7:0] s, input logic [3:0] ix, input bit last);
    int g;
    g = 0;
    if ($urandom_range(0, 3) == 0) tick;
    in_valid = 1'b1;
    in_sum   = s;
    in_index = ix;
    while (!in_ready && g < 50) begin
      tick;
      g++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    tick;
    in_valid = 1'b0;
    in_sum   = $urandom_range(0, 255);
    if (last) chk("out_valid_latency", 32'(out_valid), 32'd1);
    else      chk("out_valid_early", 32'(out_valid), 32'd0);
  endtask

  task automatic send_frame(input vec_t v);
    sb.push_back('{d: v.exp, e: v.err});
    for (int k = 0; k < 9; k++) drive_beat(v.sums[k], v.idx[k], k == 8);
  endtask

  task automatic check_frame(input string nm);
    int   g;
    exp_t e;
    g = 0;
    while (!out_valid && g < 50) begin
      tick;
      g++;
    end
    if (!out_valid) chk({nm, "_out_valid_timeout"}, 32'd0, 32'd1);
    if (sb.size() == 0) begin
      chk({nm, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      for (int i = 0; i < 9; i++)
        chk($sformatf("%s data_out%0d", nm, i), 32'(w_dout[i]), 32'(e.d[i]));
      chk({nm, " err"}, 32'(err), 32'(e.e));
    end
    if (out_ready) begin
      tick;
      chk({nm, " in_ready_after_handoff"}, 32'(in_ready), 32'd1);
      chk({nm, " out_valid_after_handoff"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    // Identity
    vecs[0] = '{sums: pk8({8'd1, 8'd3, 8'd6, 8'd10, 8'd15, 8'd21, 8'd28, 8'd36, 8'd45}),
                idx:  pk4({4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8}),
                exp:  pk8({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}),
                err:  1'b0};
    // Zero sums restart the running sum
    vecs[1] = '{sums: pk8({8'd5, 8'd0, 8'd7, 8'd9, 8'd0, 8'd0, 8'd3, 8'd4, 8'd6}),
                idx:  pk4({4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8}),
                exp:  pk8({8'd5, 8'd0, 8'd7, 8'd2, 8'd0, 8'd0, 8'd3, 8'd1, 8'd2}),
                err:  1'b0};
    // Reversed permutation
    vecs[2] = '{sums: pk8({8'd1, 8'd3, 8'd6, 8'd10, 8'd15, 8'd21, 8'd28, 8'd36, 8'd45}),
                idx:  pk4({4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}),
                exp:  pk8({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}),
                err:  1'b0};
    // Bad index 9 on beat 1 (its wrapped x=100 discarded, slot 1 stays 0)
    vecs[3] = '{sums: pk8({8'd200, 8'd44, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd110}),
                idx:  pk4({4'd0, 4'd9, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8}),
                exp:  pk8({8'd200, 8'd0, 8'd6, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10}),
                err:  1'b1};
    // Visible wrap: 4-250 = 10, 20-4 = 16
    vecs[4] = '{sums: pk8({8'd250, 8'd4, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80}),
                idx:  pk4({4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8}),
                exp:  pk8({8'd250, 8'd10, 8'd16, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10}),
                err:  1'b0};
    // Duplicate indices (later wins), unwritten slots 7/8, then max index 15
    vecs[5] = '{sums: pk8({8'd1, 8'd3, 8'd6, 8'd10, 8'd15, 8'd21, 8'd28, 8'd36, 8'd45}),
                idx:  pk4({4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd15}),
                exp:  pk8({8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0}),
                err:  1'b1};
    // Frame after a mid-frame reset; slots 5..8 must not show stale values
    rv      = '{sums: pk8({8'd1, 8'd3, 8'd6, 8'd10, 8'd15, 8'd21, 8'd28, 8'd36, 8'd45}),
                idx:  pk4({4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4}),
                exp:  pk8({8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0}),
                err:  1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_index  = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    for (int i = 0; i < 9; i++) chk($sformatf("reset data_out%0d", i), 32'(w_dout[i]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick;
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v]);
      check_frame($sformatf("vec%0d", v));
    end

    // Backpressure: hold the frame for 5 cycles while junk beats are offered
    out_ready = 1'b0;
    send_frame(vecs[0]);
    in_valid  = 1'b1;
    in_sum    = 8'hAA;
    in_index  = 4'd0;
    for (int c = 0; c < 5; c++) begin
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp data_out0", 32'(data_out0), 32'd1);
      chk("bp data_out8", 32'(data_out8), 32'd9);
      chk("bp err", 32'(err), 32'd0);
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_frame("bp");
    // No junk beat may have leaked into the next frame
    send_frame(vecs[1]);
    check_frame("post_bp");

    // Reset after 4 beats, then a full new frame
    drive_beat(8'd7, 4'd5, 1'b0);
    drive_beat(8'd8, 4'd6, 1'b0);
    drive_beat(8'd9, 4'd7, 1'b0);
    drive_beat(8'd10, 4'd8, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset data_out5", 32'(data_out5), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick;
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    send_frame(rv);
    check_frame("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule : tb_subtract_and_restore

`default_nettype wire
